scan_chain_controller: RTL
==========================

// Module: scan_chain_controller
// PURPOSE
//  Initiator side of the DES scan chain: drives scan_enable/scan_in into a target chain and captures scan_out.
//  Host issues one command: shift a CHAIN_LEN-bit vector in, optionally run the target for N functional cycles,
//  then read the chain back without destroying it. Sits between the SPI host bridge and des_fixedkey_scanchain.
// PARAMETERS
//  CHAIN_LEN  134  total target chain length in bits (FSM bits + L32 + R32 + OUT64); parent sets it to match target
//  RUN_W      16   width of the functional-run cycle count
// PORTS
//  clk            in   1          single clock, shared with target
//  rst_n          in   1          asynchronous, active-low reset
//  cmd_valid      in   1          command offered
//  cmd_ready      out  1          high only in IDLE; accept = cmd_valid & cmd_ready at rising edge
//  cmd_run        in   RUN_W      functional cycles between shift-in and shift-out; 0 = single exchange shift
//  cmd_data       in   CHAIN_LEN  vector to load; bit 0 driven on scan_in first
//  rsp_valid      out  1          result available
//  rsp_ready      in   1          host takes result
//  rsp_data       out  CHAIN_LEN  captured chain; bit k = scan_out sampled on shift-out cycle k
//  busy           out  1          high in every state except IDLE
//  run_active     out  1          high during RUN (parent may use it to gate target start)
//  scan_enable    out  1          to target
//  scan_in        out  1          to target chain head
//  scan_out       in   1          from target chain tail (combinational from last flop)
// BEHAVIOUR
//  Reset: state IDLE; cmd_ready=1; rsp_valid=0; rsp_data=0; busy=0; run_active=0; scan_enable=0; scan_in=0.
//  States: IDLE -> SHIFT_IN -> (RUN -> SHIFT_OUT) -> RESP -> IDLE.
//  IDLE: on accept, latch cmd_data into shift reg and cmd_run into run counter; go to SHIFT_IN.
//  SHIFT_IN: scan_enable=1 for exactly CHAIN_LEN consecutive cycles, starting the cycle after accept.
//   In cycle k, scan_in = cmd_data[k]; on that cycle's closing edge, scan_out is sampled into capture bit k.
//   cmd_run==0: capture is the result (pre-load chain contents); go to RESP.
//   cmd_run!=0: capture discarded; go to RUN.
//  RUN: scan_enable=0, run_active=1 for exactly cmd_run cycles; then SHIFT_OUT.
//  SHIFT_OUT: scan_enable=1 for CHAIN_LEN cycles; scan_in = scan_out (recirculate, chain restored at end);
//   scan_out captured into bit k as in SHIFT_IN; then RESP.
//  RESP: rsp_valid=1, rsp_data = capture; both held stable until rsp_ready; on handshake go to IDLE
//   (cmd_ready rises the cycle after). cmd_valid during RESP is not accepted.
//  scan_enable, scan_in, run_active are registered (no combinational path from host ports).
//  Bit counter: $clog2(CHAIN_LEN) bits, 0..CHAIN_LEN-1, terminal at CHAIN_LEN-1, no wrap past terminal.
//  cmd_run = 2^RUN_W-1 runs the full count; no overflow, no early exit.
//  Latency accept->rsp_valid: CHAIN_LEN cycles (run=0); 2*CHAIN_LEN + cmd_run cycles (run!=0).
//  Changes to cmd_* while busy are ignored. Reset mid-operation: immediate return to IDLE with reset values;
//   partial capture discarded; target chain contents undefined (host reissues).
// STRUCTURE
//  Shared include scan_ctrl_defs.vh: state encodings (IDLE, SHIFT_IN, RUN, SHIFT_OUT, RESP), default CHAIN_LEN.
//  One sub-module, scan_ctrl_shifter: CHAIN_LEN shift register with parallel load, serial out (bit 0 first),
//   and serial capture in at bit index; FSM and counters stay in the top module.
// TESTING (target = chain of scan_register models, CHAIN_LEN=8 unless noted)
//  Reset, then idle 5 cycles -> all outputs at reset values; scan_enable never high.
//  Chain preloaded 8'hA5, cmd run=0 data=8'h3C -> 8 shift cycles, rsp_data=8'hA5, chain holds 8'h3C.
//  cmd run=3 data=8'h81 on incrementing-counter target -> scan_enable low exactly 3 cycles, rsp shows +3,
//   chain after SHIFT_OUT still equals rsp_data (recirculation check).
//  rsp_ready held low 10 cycles with cmd_valid high -> rsp_data stable, cmd_ready stays 0, no second accept.
//  rst_n pulsed low at shift cycle 4 -> outputs reset asynchronously; next command completes normally.
//  CHAIN_LEN=134 with des_fixedkey_scanchain: load L/R/FSM state, run 16 cycles -> rsp OUT field = known DES result.

Source files
------------

// File: rtl/scan_chain_controller_pkg.sv
// Shared definitions for the scan chain controller slice.
// Contents:
//   DEFAULT_CHAIN_LEN / DEFAULT_RUN_W : default sizes matching the DES scan target
//   state_e                           : controller FSM state encoding
package scan_chain_controller_pkg;

  localparam int DEFAULT_CHAIN_LEN = 134;
  localparam int DEFAULT_RUN_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SHIFT_IN  = 3'd1,
    ST_RUN       = 3'd2,
    ST_SHIFT_OUT = 3'd3,
    ST_RESP      = 3'd4
  } state_e;

endpackage

// File: rtl/scan_chain_controller_if.sv
// Host-side command/response bundle of the scan chain controller.
// Signals:
//   cmd_valid/cmd_ready : command handshake (host -> controller)
//   cmd_run             : functional cycles to run between shift-in and shift-out
//   cmd_data            : vector to load, bit 0 shifted first
//   rsp_valid/rsp_ready : response handshake (controller -> host)
//   rsp_data            : captured chain contents
// Modports: master = host side, slave = controller side.
interface scan_chain_controller_if
  import scan_chain_controller_pkg::*;
#(
  parameter int CHAIN_LEN = DEFAULT_CHAIN_LEN,
  parameter int RUN_W     = DEFAULT_RUN_W
) ();

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [RUN_W-1:0]     cmd_run;
  logic [CHAIN_LEN-1:0] cmd_data;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [CHAIN_LEN-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_run, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_run, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/scan_chain_controller_shifter.sv
// scan_ctrl_shifter: CHAIN_LEN-bit shift register holding the outgoing vector
// and the incoming capture at the same time.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_en     : parallel load of load_data
//   load_data   : vector to send
//   shift_en    : shift one position toward bit 0
//   capture_in  : serial capture bit, enters at the top
//   data        : current register contents
//   next_bit    : bit that will be driven on the following shift cycle
module scan_ctrl_shifter #(
  parameter int WIDTH = 134
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             capture_in,
  output logic [WIDTH-1:0] data,
  output logic             next_bit
);

  logic [WIDTH-1:0] data_q, data_d;

  // Outgoing bits leave from bit 0 while captured bits enter at the top, so
  // after WIDTH shifts the bit captured on shift cycle k sits at index k.
  always_comb begin
    data_d = data_q;
    if (load_en) begin
      data_d = load_data;
    end else if (shift_en) begin
      data_d = {capture_in, data_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data     = data_q;
  // Bit 0 is already on scan_in during the current cycle; bit 1 is next.
  assign next_bit = data_q[1];

endmodule

// File: rtl/scan_chain_controller.sv
// scan_chain_controller: initiator side of the DES scan chain. Shifts a
// command vector into the target, optionally runs the target for cmd_run
// functional cycles, then reads the chain back non-destructively.
// Ports:
//   clk, rst_n   : shared clock, asynchronous active-low reset
//   host         : command/response bundle (slave modport)
//   busy         : high in every state except IDLE
//   run_active   : high while the target runs functionally
//   scan_enable  : target scan enable
//   scan_in      : target chain head
//   scan_out     : target chain tail
module scan_chain_controller
  import scan_chain_controller_pkg::*;
#(
  parameter int CHAIN_LEN = DEFAULT_CHAIN_LEN,
  parameter int RUN_W     = DEFAULT_RUN_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  scan_chain_controller_if.slave  host,
  output logic                    busy,
  output logic                    run_active,
  output logic                    scan_enable,
  output logic                    scan_in,
  input  logic                    scan_out
);

  localparam int                CNT_W    = $clog2(CHAIN_LEN);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(CHAIN_LEN - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [RUN_W-1:0]     run_cnt_q, run_cnt_d;
  logic                 scan_en_q, scan_en_d;
  logic                 scan_in_q, scan_in_d;
  logic                 run_active_q, run_active_d;
  logic                 recirc_q, recirc_d;
  logic                 load_en, shift_en;
  logic                 next_bit;
  logic [CHAIN_LEN-1:0] shreg;

  scan_ctrl_shifter #(.WIDTH(CHAIN_LEN)) u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_en    (load_en),
    .load_data  (host.cmd_data),
    .shift_en   (shift_en),
    .capture_in (scan_out),
    .data       (shreg),
    .next_bit   (next_bit)
  );

  // Next-state logic. Target-facing controls are computed one cycle early so
  // they come straight from flops; the bit counter stops at LAST_BIT and is
  // rearmed explicitly on entry to each shift phase.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    run_cnt_d    = run_cnt_q;
    scan_en_d    = scan_en_q;
    scan_in_d    = scan_in_q;
    run_active_d = run_active_q;
    recirc_d     = recirc_q;
    load_en      = 1'b0;
    shift_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (host.cmd_valid) begin
          state_d   = ST_SHIFT_IN;
          load_en   = 1'b1;
          run_cnt_d = host.cmd_run;
          bit_cnt_d = '0;
          scan_en_d = 1'b1;
          scan_in_d = host.cmd_data[0];
        end
      end
      ST_SHIFT_IN: begin
        shift_en  = 1'b1;
        scan_in_d = next_bit;
        if (bit_cnt_q == LAST_BIT) begin
          scan_en_d = 1'b0;
          scan_in_d = 1'b0;
          if (run_cnt_q == '0) begin
            state_d = ST_RESP;
          end else begin
            state_d      = ST_RUN;
            run_active_d = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        run_cnt_d = run_cnt_q - RUN_W'(1);
        if (run_cnt_q == RUN_W'(1)) begin
          state_d      = ST_SHIFT_OUT;
          run_active_d = 1'b0;
          scan_en_d    = 1'b1;
          recirc_d     = 1'b1;
          bit_cnt_d    = '0;
        end
      end
      ST_SHIFT_OUT: begin
        shift_en = 1'b1;
        if (bit_cnt_q == LAST_BIT) begin
          state_d   = ST_RESP;
          scan_en_d = 1'b0;
          recirc_d  = 1'b0;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (host.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and control registers; reset aborts any transfer immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      run_cnt_q    <= '0;
      scan_en_q    <= 1'b0;
      scan_in_q    <= 1'b0;
      run_active_q <= 1'b0;
      recirc_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      run_cnt_q    <= run_cnt_d;
      scan_en_q    <= scan_en_d;
      scan_in_q    <= scan_in_d;
      run_active_q <= run_active_d;
      recirc_q     <= recirc_d;
    end
  end

  // During read-back the tail bit must re-enter the head in the same cycle to
  // leave the chain unchanged after CHAIN_LEN shifts. The select is a flop and
  // the data comes from the target's last flop, so nothing from the host
  // reaches scan_in combinationally.
  assign scan_in     = recirc_q ? scan_out : scan_in_q;
  assign scan_enable = scan_en_q;
  assign run_active  = run_active_q;
  assign busy        = (state_q != ST_IDLE);

  assign host.cmd_ready = (state_q == ST_IDLE);
  assign host.rsp_valid = (state_q == ST_RESP);
  assign host.rsp_data  = (state_q == ST_RESP) ? shreg : '0;

endmodule
